// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial adder sequencing one full-adder cell and a carry flop, LSB first
module full_adder_structural (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);
   logic ab_x, ab_a, c_a;
   xor g_x0 (ab_x, a, b);
   xor g_x1 (sum, ab_x, cin);
   and g_a0 (ab_a, a, b);
   and g_a1 (c_a, ab_x, cin);
   or  g_o0 (cout, ab_a, c_a);
endmodule

module serial_adder_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state, state_nx;
   logic [WIDTH-1:0] sh_a, sh_b, sh_s, s_nx;
   logic carry, fa_sum, fa_cout, accept, last;
   logic [CW-1:0] cnt;
   full_adder_structural u_fa (
      .a(sh_a[0]),
      .b(sh_b[0]),
      .cin(carry),
      .sum(fa_sum),
      .cout(fa_cout)
   );
   assign s_nx = (sh_s >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));
   assign busy = (state == RUN);
   assign done = (state == DONE);
   // next state: operands are accepted only outside RUN, so start while busy is ignored
   always_comb begin
      accept   = (state != RUN) && start;
      last     = (state == RUN) && (cnt == LAST);
      state_nx = (state == RUN) ? (last ? DONE : RUN) : (start ? RUN : IDLE);
   end
   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end
   // datapath: capture on accept, shift one bit per RUN cycle, publish result on the last bit
   always_ff @(posedge clk) begin
      if (rst) begin
         sh_a  <= '0;
         sh_b  <= '0;
         sh_s  <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         sum   <= '0;
         cout  <= 1'b0;
      end else if (accept) begin
         sh_a  <= a;
         sh_b  <= b;
         carry <= cin;
         cnt   <= '0;
      end else if (state == RUN) begin
         sh_a  <= sh_a >> 1;
         sh_b  <= sh_b >> 1;
         sh_s  <= s_nx;
         carry <= fa_cout;
         cnt   <= cnt + 1'b1;
         if (last) begin
            sum  <= s_nx;
            cout <= fa_cout;
         end
      end
   end
endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
Bit-serial multi-bit adder controller. It sequences one single-bit full-adder cell (full_adder_structural) plus a carry flip-flop across a WIDTH-bit operand pair, LSB first. It is the area-minimal alternative to a ripple chain of WIDTH full-adder cells. Operands are captured on a start/busy/done handshake, and the registered result is presented when done pulses.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 1..32.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
start  input  1  request an add; sampled only when accepting (IDLE or DONE)
a  input  WIDTH  operand A, captured on accepted start
b  input  WIDTH  operand B, captured on accepted start
cin  input  1  carry-in, captured on accepted start
busy  output  1  high while bits are being processed (RUN state)
done  output  1  one-cycle pulse: sum/cout newly valid
sum  output  WIDTH  registered result; holds last completed result
cout  output  1  registered carry-out; holds last completed value

Behaviour:
- One clock; synchronous, active-high reset. On rst: state=IDLE, busy=0, done=0, sum=0, cout=0; internal shift registers, carry flop and bit counter cleared. rst has priority over all other inputs.
- Internal storage:
  - sh_a and sh_b: WIDTH bits each.
  - sh_s: WIDTH bits, result shift register.
  - carry: 1 bit.
  - cnt: $clog2(WIDTH+1) bits.
- Exactly one full_adder_structural instance:
  - a = sh_a[0], b = sh_b[0], cin = carry.
  - Its sum and cout feed sh_s and carry.
- FSM states IDLE, RUN, DONE:
  - IDLE:
    - start=1: sh_a<=a, sh_b<=b, carry<=cin, cnt<=0 -> RUN.
    - Else stay in IDLE.
  - RUN, each cycle:
    - sh_s <= {fa_sum, sh_s[WIDTH-1:1]}; carry <= fa_cout.
    - sh_a and sh_b shift right by 1 with zero fill; cnt <= cnt+1.
    - When cnt==WIDTH-1 (last bit): next state DONE; sum <= {fa_sum, sh_s[WIDTH-1:1]}; cout <= fa_cout.
  - DONE: done=1 for exactly this cycle.
    - start=1: capture new operands as in IDLE -> RUN (back-to-back, no idle bubble).
    - Else -> IDLE.
- busy = (state==RUN). done = (state==DONE). Both are decoded from registered state (glitch-free, no combinational path from inputs).
- Latency: start sampled at edge E0. RUN occupies the WIDTH cycles after E0. done is high in the cycle following edge E0+WIDTH, i.e. done is visible WIDTH+1 cycles after start is asserted.
- Throughput: one add per WIDTH+1 cycles back-to-back.
- Arithmetic: {cout,sum} == a + b + cin (mod 2^(WIDTH+1)); unsigned.
- Boundary conditions:
  - start while busy: ignored; operands a/b/cin are not re-sampled; the in-flight operation is unaffected.
  - a, b, cin changing during RUN: no effect (captured values only).
  - sum/cout do not change during RUN. They change only on the DONE-entry edge or on reset, and hold indefinitely in IDLE.
  - rst mid-RUN: abort; next cycle IDLE with all outputs 0; no done pulse.
  - WIDTH=1: RUN lasts one cycle; done is visible 2 cycles after start.
  - Carry wrap: all-ones + 1 gives sum=0, cout=1.

Test Plan:
1. WIDTH=8, a=0x5A, b=0x3C, cin=0, start pulse -> busy high 8 cycles; done visible 9 cycles after start; sum=0x96, cout=0.
2. a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0x00, cin=1 -> sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
3. Start a=0x12, b=0x34; at RUN cycle 3 drive start=1, a=0xFF, b=0xFF -> second request ignored; sum=0x46, cout=0; exactly one done pulse.
4. Hold start=1 continuously with a=0x01, b=0x01 -> done every 9 cycles, sum=0x02 each time; busy low only during done cycles.
5. Reset at RUN cycle 4 of a=0xAA+0x55 -> next cycle busy=0, done=0, sum=0, cout=0; no done pulse follows. Then a new start with a=0x0F, b=0x01 -> sum=0x10.
6. WIDTH=1 build: a=1, b=1, cin=1 -> done visible 2 cycles after start; sum=1, cout=1. Randomized 1000 ops at WIDTH=8 checked against a+b+cin.
